// File: rtl/qrs_beat_controller.sv
// QRS beat qualifier: confirmation run, refractory blanking, RR interval, beat count, asystole alarm.
// Optional RR_AVG_EN macro adds a running RR average output rr_avg.
module qrs_beat_controller #(
    parameter int CONFIRM_N = 3,
    parameter int REFRACT_N = 72,
    parameter int ASYS_N    = 1080,
    parameter int RR_W      = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sample_valid,
    input  logic            qrs_raw,
    input  logic            enable,
    output logic            beat_valid,
    output logic [RR_W-1:0] rr_interval,
    output logic [15:0]     beat_count,
    output logic            asystole,
`ifdef RR_AVG_EN
    output logic [RR_W-1:0] rr_avg,
`endif
    output logic [1:0]      state
);

    typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, CONFIRM = 2'd2, REFRACT = 2'd3} state_t;

    localparam logic [RR_W-1:0] RR_MAX = {RR_W{1'b1}};

    state_t          st;
    logic [3:0]      run;
    logic [RR_W-1:0] refract;
    logic [RR_W-1:0] rr_cnt;
    logic [RR_W-1:0] rr_inc;
    logic            have_beat;
    logic            beat;

    assign state  = st;
    assign rr_inc = (rr_cnt == RR_MAX) ? rr_cnt : rr_cnt + 1'b1;

    // Confirming sample: the run reaches CONFIRM_N on this strobe.
    assign beat = sample_valid && qrs_raw &&
                  ((st == SEARCH  && CONFIRM_N == 1) ||
                   (st == CONFIRM && (run + 4'd1) == 4'(CONFIRM_N)));

`ifdef RR_AVG_EN
    logic            avg_seeded;
    logic [RR_W+2:0] avg_sum;
    assign avg_sum = ({3'b000, rr_avg} << 3) - {3'b000, rr_avg} + {3'b000, rr_inc};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= IDLE;
            run         <= '0;
            refract     <= '0;
            rr_cnt      <= '0;
            have_beat   <= 1'b0;
            beat_valid  <= 1'b0;
            rr_interval <= '0;
            beat_count  <= '0;
            asystole    <= 1'b0;
`ifdef RR_AVG_EN
            rr_avg      <= '0;
            avg_seeded  <= 1'b0;
`endif
        end else begin
            beat_valid <= 1'b0;
            if (!enable) begin
                st          <= IDLE;
                run         <= '0;
                refract     <= '0;
                rr_cnt      <= '0;
                have_beat   <= 1'b0;
                rr_interval <= '0;
                beat_count  <= '0;
                asystole    <= 1'b0;
`ifdef RR_AVG_EN
                rr_avg      <= '0;
                avg_seeded  <= 1'b0;
`endif
            end else if (st == IDLE) begin
                st <= SEARCH;
            end else if (sample_valid) begin
                if (beat) begin
                    beat_valid  <= 1'b1;
                    beat_count  <= beat_count + 16'd1;
                    asystole    <= 1'b0;
                    st          <= REFRACT;
                    refract     <= '0;
                    run         <= '0;
                    rr_interval <= have_beat ? rr_inc : '0;
                    rr_cnt      <= '0;
                    have_beat   <= 1'b1;
`ifdef RR_AVG_EN
                    if (have_beat) begin
                        rr_avg     <= avg_seeded ? avg_sum[RR_W+2:3] : rr_inc;
                        avg_seeded <= 1'b1;
                    end
`endif
                end else begin
                    rr_cnt <= rr_inc;
                    if (rr_inc == RR_W'(ASYS_N))
                        asystole <= 1'b1;
                    case (st)
                        SEARCH: if (qrs_raw) begin
                            run <= 4'd1;
                            st  <= CONFIRM;
                        end
                        CONFIRM: if (qrs_raw) begin
                            run <= run + 4'd1;
                        end else begin
                            run <= '0;
                            st  <= SEARCH;
                        end
                        REFRACT: if ((refract + 1'b1) == RR_W'(REFRACT_N)) begin
                            refract <= '0;
                            st      <= SEARCH;
                        end else begin
                            refract <= refract + 1'b1;
                        end
                        default: st <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_qrs_beat_controller.sv
// Directed bench for qrs_beat_controller: reset, confirm/abort, refractory, RR, asystole, enable priority.
module tb_qrs_beat_controller;

    localparam int RR_W = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            sample_valid = 1'b0;
    logic            qrs_raw = 1'b0;
    logic            enable = 1'b0;
    logic            beat_valid;
    logic [RR_W-1:0] rr_interval;
    logic [15:0]     beat_count;
    logic            asystole;
    logic [1:0]      state;
`ifdef RR_AVG_EN
    logic [RR_W-1:0] rr_avg;
`endif

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int sidx = 0;

    always #5 clk = ~clk;

    qrs_beat_controller #(.CONFIRM_N(3), .REFRACT_N(5), .ASYS_N(20), .RR_W(RR_W)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .qrs_raw(qrs_raw), .enable(enable),
        .beat_valid(beat_valid), .rr_interval(rr_interval), .beat_count(beat_count),
        .asystole(asystole),
`ifdef RR_AVG_EN
        .rr_avg(rr_avg),
`endif
        .state(state)
    );

    // One sample strobe per 4 clocks; beat_valid cycles are tallied in pulses.
    task automatic do_sample(input logic q);
        @(posedge clk); #1;
        sample_valid = 1'b1; qrs_raw = q;
        @(posedge clk); #1;
        sample_valid = 1'b0; qrs_raw = 1'b0;
        if (beat_valid) pulses++;
        repeat (2) begin
            @(posedge clk); #1;
            if (beat_valid) pulses++;
        end
        sidx++;
    endtask

    task automatic run_to(input int n, input logic q);
        while (sidx <= n) do_sample(q);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
        tests++; if (beat_valid !== 1'b0 || asystole !== 1'b0) begin fails++; $display("FAIL reset_flags: got bv=%b as=%b want 0 0", beat_valid, asystole); end
        tests++; if (rr_interval !== 0 || beat_count !== 0) begin fails++; $display("FAIL reset_counts: got rr=%0d cnt=%0d want 0 0", rr_interval, beat_count); end
        rst = 1'b0; enable = 1'b1;
        @(posedge clk); #1;
        do_sample(1'b0); do_sample(1'b1); do_sample(1'b1);
        tests++; if (state !== 2'd2) begin fails++; $display("FAIL pre_rst_confirm: got %0d want 2", state); end
        #2 rst = 1'b1;
        #1;
        tests++; if (state !== 2'd0) begin fails++; $display("FAIL rst_async_state: got %0d want 0", state); end
        pulses = 0;
        do_sample(1'b1);
        tests++; if (pulses !== 0 || beat_count !== 0) begin fails++; $display("FAIL rst_no_beat: got pulses=%0d cnt=%0d want 0 0", pulses, beat_count); end
        enable = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (state !== 2'd0 || beat_valid !== 1'b0 || asystole !== 1'b0 || rr_interval !== 0 || beat_count !== 0) begin
            fails++; $display("FAIL rst_release_idle: got st=%0d bv=%b as=%b rr=%0d cnt=%0d want all 0", state, beat_valid, asystole, rr_interval, beat_count);
        end
    endtask

    task automatic test_first_beat;
        enable = 1'b1;
        @(posedge clk); #1;
        tests++; if (state !== 2'd1) begin fails++; $display("FAIL enable_search: got %0d want 1", state); end
        sidx = 0; pulses = 0;
        run_to(9, 1'b0);
        run_to(12, 1'b1);
        tests++; if (pulses !== 1) begin fails++; $display("FAIL first_beat_pulse: got %0d want 1", pulses); end
        tests++; if (rr_interval !== 0 || beat_count !== 1) begin fails++; $display("FAIL first_beat_rr_cnt: got rr=%0d cnt=%0d want 0 1", rr_interval, beat_count); end
        tests++; if (state !== 2'd3) begin fails++; $display("FAIL first_beat_state: got %0d want 3", state); end
    endtask

    task automatic test_abort;
        run_to(29, 1'b0);
        run_to(31, 1'b1);
        tests++; if (state !== 2'd2 || asystole !== 1'b0) begin fails++; $display("FAIL abort_mid: got st=%0d as=%b want 2 0", state, asystole); end
        run_to(32, 1'b0);
        tests++; if (state !== 2'd1 || beat_count !== 1 || pulses !== 1) begin fails++; $display("FAIL abort_end: got st=%0d cnt=%0d pulses=%0d want 1 1 1", state, beat_count, pulses); end
        // 20 samples since the beat at 12 lands on sample 32.
        tests++; if (asystole !== 1'b1) begin fails++; $display("FAIL asys_after_abort: got %b want 1", asystole); end
    endtask

    task automatic test_continuous;
        run_to(39, 1'b0);
        run_to(42, 1'b1);
        tests++; if (pulses !== 2 || rr_interval !== 30 || beat_count !== 2) begin fails++; $display("FAIL beat42: got pulses=%0d rr=%0d cnt=%0d want 2 30 2", pulses, rr_interval, beat_count); end
        tests++; if (asystole !== 1'b0 || state !== 2'd3) begin fails++; $display("FAIL beat42_flags: got as=%b st=%0d want 0 3", asystole, state); end
`ifdef RR_AVG_EN
        tests++; if (rr_avg !== 30) begin fails++; $display("FAIL avg_seed: got %0d want 30", rr_avg); end
`endif
        run_to(47, 1'b1);
        tests++; if (pulses !== 2 || state !== 2'd1) begin fails++; $display("FAIL refract_blank: got pulses=%0d st=%0d want 2 1", pulses, state); end
        run_to(50, 1'b1);
        tests++; if (pulses !== 3 || rr_interval !== 8 || beat_count !== 3) begin fails++; $display("FAIL beat50: got pulses=%0d rr=%0d cnt=%0d want 3 8 3", pulses, rr_interval, beat_count); end
`ifdef RR_AVG_EN
        tests++; if (rr_avg !== 27) begin fails++; $display("FAIL avg_50: got %0d want 27", rr_avg); end
`endif
    endtask

    task automatic test_asystole;
        run_to(69, 1'b0);
        tests++; if (asystole !== 1'b0) begin fails++; $display("FAIL asys_early: got %b want 0", asystole); end
        run_to(70, 1'b0);
        tests++; if (asystole !== 1'b1) begin fails++; $display("FAIL asys_set: got %b want 1", asystole); end
        run_to(72, 1'b0);
        run_to(75, 1'b1);
        tests++; if (asystole !== 1'b0 || rr_interval !== 25 || beat_count !== 4 || pulses !== 4) begin
            fails++; $display("FAIL beat75: got as=%b rr=%0d cnt=%0d pulses=%0d want 0 25 4 4", asystole, rr_interval, beat_count, pulses);
        end
`ifdef RR_AVG_EN
        tests++; if (rr_avg !== 26) begin fails++; $display("FAIL avg_75: got %0d want 26", rr_avg); end
`endif
    endtask

    task automatic test_enable_drop;
        run_to(76, 1'b0);
        tests++; if (state !== 2'd3) begin fails++; $display("FAIL pre_drop_state: got %0d want 3", state); end
        @(posedge clk); #1 enable = 1'b0;
        @(posedge clk); #1 enable = 1'b1;
        tests++; if (state !== 2'd0 || beat_count !== 0 || rr_interval !== 0 || asystole !== 1'b0) begin
            fails++; $display("FAIL drop_clear: got st=%0d cnt=%0d rr=%0d as=%b want 0 0 0 0", state, beat_count, rr_interval, asystole);
        end
`ifdef RR_AVG_EN
        tests++; if (rr_avg !== 0) begin fails++; $display("FAIL drop_avg: got %0d want 0", rr_avg); end
`endif
        @(posedge clk); #1;
        tests++; if (state !== 2'd1) begin fails++; $display("FAIL drop_resume: got %0d want 1", state); end
    endtask

    task automatic test_enable_vs_beat;
        pulses = 0;
        do_sample(1'b1); do_sample(1'b1);
        @(posedge clk); #1;
        sample_valid = 1'b1; qrs_raw = 1'b1; enable = 1'b0;
        @(posedge clk); #1;
        sample_valid = 1'b0; qrs_raw = 1'b0;
        tests++; if (beat_valid !== 1'b0 || state !== 2'd0 || beat_count !== 0) begin
            fails++; $display("FAIL enable_wins: got bv=%b st=%0d cnt=%0d want 0 0 0", beat_valid, state, beat_count);
        end
        enable = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_hold_and_rearm;
        qrs_raw = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        tests++; if (state !== 2'd1) begin fails++; $display("FAIL hold_no_strobe: got %0d want 1", state); end
        qrs_raw = 1'b0;
        pulses = 0;
        do_sample(1'b0); do_sample(1'b1); do_sample(1'b1); do_sample(1'b1);
        tests++; if (pulses !== 1 || rr_interval !== 0 || beat_count !== 1) begin
            fails++; $display("FAIL rearm_first: got pulses=%0d rr=%0d cnt=%0d want 1 0 1", pulses, rr_interval, beat_count);
        end
    endtask

    initial begin
        test_reset;
        test_first_beat;
        test_abort;
        test_continuous;
        test_asystole;
        test_enable_drop;
        test_enable_vs_beat;
        test_hold_and_rearm;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
